// File: rtl/string_loader.sv
// string_loader: packs a stream of ASCII characters little-endian into one
// zero-padded word and holds it until the downstream stage acknowledges it.
//
// state | meaning
// FILL  | accepting characters into the next free slot
// HOLD  | packed word complete, waiting for string_ready
module string_loader #(
    parameter int CHAR_W    = 8,
    parameter int MAX_CHARS = 8,
    parameter int CNT_W     = 4,
    parameter int STR_W     = CHAR_W * MAX_CHARS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic              flush,
    output logic [STR_W-1:0]  string_data,
    output logic              string_valid,
    input  logic              string_ready,
    output logic [CNT_W-1:0]  char_count
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state, state_next;

    logic accept;
    logic is_null;
    logic last_slot;

    assign char_ready   = (state == FILL);
    assign string_valid = (state == HOLD);
    assign accept       = char_valid & char_ready;
    assign is_null      = (char_in == '0);
    assign last_slot    = (char_count == CNT_W'(MAX_CHARS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a null, the final slot or a flush ends the string; ack restarts.
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (accept && (is_null || last_slot)) begin
                    state_next = HOLD;
                end else if (flush) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (string_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Packed word and count: write the accepted char into slot char_count,
    // clear everything when the held word is acknowledged.
    always_ff @(posedge clk) begin
        if (reset) begin
            string_data <= '0;
            char_count  <= '0;
        end else if (state == HOLD) begin
            if (string_ready) begin
                string_data <= '0;
                char_count  <= '0;
            end
        end else if (accept && !is_null) begin
            for (int i = 0; i < MAX_CHARS; i++) begin
                if (char_count == CNT_W'(i)) begin
                    string_data[CHAR_W*i +: CHAR_W] <= char_in;
                end
            end
            char_count <= char_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_string_loader.sv
// Directed and randomized-handshake bench for string_loader.
module tb_string_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        flush;
    logic [63:0] string_data;
    logic        string_valid;
    logic        string_ready;
    logic [3:0]  char_count;

    int n_checks = 0;
    int n_fail   = 0;

    string_loader dut (
        .clk          (clk),
        .reset        (reset),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .flush        (flush),
        .string_data  (string_data),
        .string_valid (string_valid),
        .string_ready (string_ready),
        .char_count   (char_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        char_in    = c;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
        char_in    = 8'h00;
    endtask

    task automatic ack();
        string_ready = 1'b1;
        tick();
        string_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_str"},   string_data, 64'h0);
        check({tag, "_cnt"},   64'(char_count), 64'd0);
        check({tag, "_valid"}, 64'(string_valid), 64'd0);
        check({tag, "_ready"}, 64'(char_ready), 64'd1);
    endtask

    logic [7:0]  chars [0:8];
    logic [63:0] exp_word;
    int          nchars;
    int          len;
    int          idx;
    bit          done;
    bit          acc;
    bit          ackd;

    initial begin
        reset        = 1'b1;
        char_in      = 8'h00;
        char_valid   = 1'b0;
        flush        = 1'b0;
        string_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset");

        // "Hi" followed by null
        send(8'h48);
        send(8'h69);
        check("hi_not_yet_valid", 64'(string_valid), 64'd0);
        send(8'h00);
        check("hi_valid", 64'(string_valid), 64'd1);
        check("hi_str",   string_data, 64'h0000_0000_0000_6948);
        check("hi_cnt",   64'(char_count), 64'd2);
        check("hi_ready", 64'(char_ready), 64'd0);

        // HOLD with a presented char and flush: nothing moves
        char_in    = 8'h55;
        char_valid = 1'b1;
        flush      = 1'b1;
        tick();
        tick();
        tick();
        flush = 1'b0;
        check("hold_str",   string_data, 64'h0000_0000_0000_6948);
        check("hold_cnt",   64'(char_count), 64'd2);
        check("hold_valid", 64'(string_valid), 64'd1);
        check("hold_ready", 64'(char_ready), 64'd0);
        string_ready = 1'b1;
        tick();
        string_ready = 1'b0;
        char_valid   = 1'b0;
        char_in      = 8'h00;
        check_idle("after_ack");

        // eight chars, no null
        for (int i = 0; i < 7; i++) send(8'h41 + 8'(i));
        check("full7_valid", 64'(string_valid), 64'd0);
        check("full7_cnt",   64'(char_count), 64'd7);
        send(8'h48);
        check("full_valid", 64'(string_valid), 64'd1);
        check("full_str",   string_data, 64'h4847_4645_4443_4241);
        check("full_cnt",   64'(char_count), 64'd8);
        ack();
        check_idle("full_ack");

        // flush together with an accept
        send(8'h41);
        char_in    = 8'h42;
        char_valid = 1'b1;
        flush      = 1'b1;
        tick();
        char_valid = 1'b0;
        flush      = 1'b0;
        check("flacc_valid", 64'(string_valid), 64'd1);
        check("flacc_str",   string_data, 64'h4241);
        check("flacc_cnt",   64'(char_count), 64'd2);
        ack();

        // flush alone from empty
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flempty_valid", 64'(string_valid), 64'd1);
        check("flempty_str",   string_data, 64'h0);
        check("flempty_cnt",   64'(char_count), 64'd0);
        ack();

        // null as the first char
        send(8'h00);
        check("null0_valid", 64'(string_valid), 64'd1);
        check("null0_str",   string_data, 64'h0);
        check("null0_cnt",   64'(char_count), 64'd0);
        ack();

        // string_ready during FILL does nothing
        send(8'h61);
        ack();
        check("fill_ack_cnt",   64'(char_count), 64'd1);
        check("fill_ack_str",   string_data, 64'h61);
        check("fill_ack_valid", 64'(string_valid), 64'd0);

        // reset mid-fill
        send(8'h62);
        send(8'h63);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("rst_fill");

        // reset during HOLD
        send(8'h31);
        send(8'h00);
        check("pre_rst_valid", 64'(string_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("rst_hold");

        // random handshake toggling
        for (int s = 0; s < 12; s++) begin
            len      = $urandom_range(1, 8);
            exp_word = '0;
            for (int k = 0; k < len; k++) begin
                chars[k] = 8'($urandom_range(1, 255));
                exp_word[8*k +: 8] = chars[k];
            end
            nchars = len;
            if (len < 8) begin
                chars[len] = 8'h00;
                nchars     = len + 1;
            end
            idx  = 0;
            done = 1'b0;
            for (int cyc = 0; cyc < 200 && !done; cyc++) begin
                char_valid   = (idx < nchars) ? 1'($urandom_range(0, 1)) : 1'b0;
                char_in      = (idx < nchars) ? chars[idx] : 8'h00;
                string_ready = 1'($urandom_range(0, 1));
                acc  = char_valid && char_ready;
                ackd = string_valid && string_ready;
                if (ackd) begin
                    check("rand_str",  string_data, exp_word);
                    check("rand_cnt",  64'(char_count), 64'(len));
                    check("rand_used", 64'(idx), 64'(nchars));
                    done = 1'b1;
                end
                tick();
                if (acc) idx++;
            end
            char_valid   = 1'b0;
            string_ready = 1'b0;
            check("rand_done", 64'(done), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/string_loader.md
Name: string_loader

Overview:
- Upstream feeder for the string length stage.
- Accepts ASCII characters one per cycle over a valid/ready handshake and packs them little-endian into a 64-bit string word: char 0 sits in bits [7:0].
- Terminates a string on a null byte, on reaching MAX_CHARS, or on a flush request.
- Holds the packed, zero-padded word with a valid flag until the consumer acknowledges it.

Parameters:
- CHAR_W, 8, bits per character.
- MAX_CHARS, 8, maximum characters per string; STR_W = CHAR_W*MAX_CHARS (64 at defaults).
- CNT_W, 4, width of char_count; must hold 0..MAX_CHARS.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- char_in  input  CHAR_W  incoming character; 0x00 = terminator.
- char_valid  input  1  char_in is valid this cycle.
- char_ready  output  1  loader can accept a character this cycle.
- flush  input  1  terminate the current string now with whatever has been stored.
- string  output  STR_W  packed string, char i at bits [CHAR_W*i +: CHAR_W], unused slots 0.
- string_valid  output  1  string is complete and stable.
- string_ready  input  1  consumer accepts string.
- char_count  output  CNT_W  number of non-null characters stored (0..MAX_CHARS).

Behaviour:
- Two states: FILL and HOLD. Reset enters FILL.
- Reset values: string = 0, char_count = 0, string_valid = 0. char_ready is 1 in the cycle after reset (FILL).
- Reset takes priority over everything, including mid-fill and HOLD. Any partial string is discarded and no string_valid is produced.
- char_ready = (state == FILL), registered state only; it has no combinational dependence on char_valid or string_ready.
- string_valid = (state == HOLD).
- Accept = char_valid & char_ready.

FILL state:
- Accept with char_in != 0: write char_in into slot char_count, then char_count++.
- If that was slot MAX_CHARS-1, go to HOLD next cycle.
- Accept with char_in == 0: store nothing, char_count unchanged, go to HOLD.
- flush without accept: go to HOLD with current contents. A zero-length string is legal: string = 0, char_count = 0.
- flush in the same cycle as an accept: the character is processed first (stored, or treated as the terminator), then go to HOLD.
- The result is identical to the accept alone if that accept already terminated the string.

HOLD state:
- string and char_count are stable.
- char_valid is ignored: no accept, the character is not consumed, and the upstream source must hold it.
- flush is ignored.
- string_ready = 1: clear string to 0 and char_count to 0, go to FILL. char_ready rises the next cycle.
- string_valid may stay high indefinitely; there is no timeout.

Timing and content rules:
- Latency: string_valid rises on the cycle after the terminating accept or flush.
- Minimum throughput is one string per (n+2) cycles for n characters: n accepts, plus 1 terminator or flush cycle if n < MAX_CHARS, plus 1 HOLD/ack cycle.
- Slots at index ≥ char_count are always 0, so the downstream null-search sees the first null at index char_count.
- For char_count = MAX_CHARS there is no null.
- char_count never exceeds MAX_CHARS and never wraps.
- string_ready while in FILL has no effect.

Test Plan:
- Reset, then send 'H'(0x48), 'i'(0x69), 0x00 → string_valid high the cycle after the null is accepted; string = 0x0000_0000_0000_6948; char_count = 2.
- With string_ready = 0 → string and char_count stay stable, char_ready = 0, and a presented char_valid is not consumed. Then pulse string_ready → string = 0 and char_ready = 1 next cycle.
- Send 8 chars 0x41..0x48 with no null → HOLD entered after the 8th accept; string = 0x4847_4645_4443_4241; char_count = 8.
- Send 0x41, then flush together with char_valid on 0x42 → string = 0x4241; char_count = 2. Also flush alone from empty FILL → string = 0; char_count = 0; string_valid = 1.
- Send 0x00 as the first char → zero-length string; char_count = 0; string = 0.
- Assert reset after 3 chars accepted and during HOLD → next cycle string = 0, char_count = 0, string_valid = 0, char_ready = 1. Random valid/ready toggling in a follow-up run must never drop or duplicate a character.
